// File: rtl/load_sequencer_pkg.sv
// Shared types and helpers for the load sequencer: FSM state encoding and
// the one-hot channel strobe generator.
package controlunit_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    COMPUTE = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam int MAX_CH = 32;

  // Bits at or above n stay clear, so an out-of-range index yields no strobe.
  function automatic logic [MAX_CH-1:0] onehot(input int idx, input int n);
    logic [MAX_CH-1:0] v;
    v = '0;
    for (int i = 0; i < MAX_CH; i++) begin
      if (i == idx && i < n) v[i] = 1'b1;
    end
    return v;
  endfunction

endpackage

// File: rtl/load_sequencer_seq_counter.sv
// Up-counter with synchronous clear (priority over enable) and a terminal
// count flag that is high while the count equals TERM.
module seq_counter #(
  parameter int W    = 8,
  parameter int TERM = 15
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_en,
  output logic o_tc
);

  logic [W-1:0] r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + W'(1);
    end
  end

  assign o_tc = (r_count == W'(TERM));

endmodule

// File: rtl/load_sequencer.sv
// Start/load/compute/done sequencer over N_CH input channels.
// Optional LOAD-phase watchdog with sticky err is built when LOAD_TIMEOUT_EN is defined.
module load_sequencer
  import controlunit_pkg::*;
#(
  parameter int N_CH           = 4,
  parameter int COMPUTE_CYCLES = 16,
  parameter int CNT_W          = 8,
  parameter int TIMEOUT_CYCLES = 64,
  localparam int CH_W          = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_start,
  input  logic            i_inputdata_ready,
  input  logic            i_ack,
  output logic [N_CH-1:0] o_loaddata,
  output logic [CH_W-1:0] o_chan_idx,
  output logic            o_compute_en,
  output logic            o_busy,
  output logic            o_done,
  output logic            o_err
);

  if (N_CH < 1 || N_CH > MAX_CH) begin : g_bad_nch
    $error("load_sequencer: N_CH out of range");
  end
  if ((2 ** CNT_W) < COMPUTE_CYCLES || COMPUTE_CYCLES < 1) begin : g_bad_cnt
    $error("load_sequencer: CNT_W too narrow for COMPUTE_CYCLES");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("load_sequencer: TIMEOUT_CYCLES must be at least 1");
  end

  localparam logic [CH_W-1:0] LAST_CH = CH_W'(N_CH - 1);

  state_t          r_state, w_state_nxt;
  logic [CH_W-1:0] r_chan_idx, w_chan_nxt;
  logic            w_cnt_tc;
  logic            w_timeout;

  // Compute counter is held at zero outside COMPUTE so each phase starts fresh.
  seq_counter #(
    .W   (CNT_W),
    .TERM(COMPUTE_CYCLES - 1)
  ) u_compute_cnt (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_clear((r_state != COMPUTE) || w_cnt_tc),
    .i_en   (r_state == COMPUTE),
    .o_tc   (w_cnt_tc)
  );

`ifdef LOAD_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic w_wd_tc;
  logic w_start_acc;
  logic r_err;

  seq_counter #(
    .W   (WD_W),
    .TERM(TIMEOUT_CYCLES - 1)
  ) u_watchdog (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_clear((r_state != LOAD) || i_inputdata_ready),
    .i_en   (r_state == LOAD),
    .o_tc   (w_wd_tc)
  );

  assign w_timeout   = (r_state == LOAD) && !i_inputdata_ready && w_wd_tc;
  assign w_start_acc = i_start && ((r_state == IDLE) || (r_state == DONE && i_ack));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_err <= 1'b0;
    end else if (w_start_acc) begin
      r_err <= 1'b0;
    end else if (w_timeout) begin
      r_err <= 1'b1;
    end
  end

  assign o_err = r_err;
`else
  assign w_timeout = 1'b0;
  assign o_err     = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= IDLE;
      r_chan_idx <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_chan_idx <= w_chan_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_chan_nxt  = r_chan_idx;
    case (r_state)
      IDLE: begin
        if (i_start) begin
          w_state_nxt = LOAD;
          w_chan_nxt  = '0;
        end
      end
      LOAD: begin
        if (i_inputdata_ready) begin
          if (r_chan_idx == LAST_CH) begin
            w_state_nxt = COMPUTE;
            w_chan_nxt  = '0;
          end else begin
            w_chan_nxt = r_chan_idx + CH_W'(1);
          end
        end else if (w_timeout) begin
          w_state_nxt = IDLE;
          w_chan_nxt  = '0;
        end
      end
      COMPUTE: begin
        if (w_cnt_tc) w_state_nxt = DONE;
      end
      DONE: begin
        if (i_ack) begin
          w_state_nxt = i_start ? LOAD : IDLE;
          w_chan_nxt  = '0;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_chan_nxt  = '0;
      end
    endcase
  end

  assign o_loaddata   = (r_state == LOAD) ? N_CH'(onehot(32'(r_chan_idx), N_CH)) : '0;
  assign o_chan_idx   = r_chan_idx;
  assign o_compute_en = (r_state == COMPUTE);
  assign o_busy       = (r_state == LOAD) || (r_state == COMPUTE);
  assign o_done       = (r_state == DONE);

endmodule

// File: tb/tb_load_sequencer.sv
// Self-checking bench for load_sequencer: a phase-level reference model scored
// every cycle, plus directed scenarios with literal expectations.
module tb_load_sequencer;

  localparam int N_CH           = 4;
  localparam int COMPUTE_CYCLES = 16;
  localparam int CNT_W          = 8;
  localparam int TIMEOUT_CYCLES = 64;

  localparam int P_IDLE    = 0;
  localparam int P_LOAD    = 1;
  localparam int P_COMPUTE = 2;
  localparam int P_DONE    = 3;

  logic       clk = 1'b0;
  logic       rstN = 1'b0;
  logic       iStart = 1'b0;
  logic       iReady = 1'b0;
  logic       iAck = 1'b0;
  logic [3:0] oLoad;
  logic [1:0] oChan;
  logic       oComputeEn, oBusy, oDone, oErr;

  int total = 0;
  int bad = 0;

  int mPhase, mPos, mLeft, mStall;
  bit mErr;

  int lat, clen;

  always #5 clk = ~clk;

  load_sequencer #(
    .N_CH          (N_CH),
    .COMPUTE_CYCLES(COMPUTE_CYCLES),
    .CNT_W         (CNT_W),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .i_clk            (clk),
    .i_rst_n          (rstN),
    .i_start          (iStart),
    .i_inputdata_ready(iReady),
    .i_ack            (iAck),
    .o_loaddata       (oLoad),
    .o_chan_idx       (oChan),
    .o_compute_en     (oComputeEn),
    .o_busy           (oBusy),
    .o_done           (oDone),
    .o_err            (oErr)
  );

  // Reference model: tracks which phase we are in, which channel is pending,
  // how many compute cycles remain and how long LOAD has stalled.
  always @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      mPhase <= P_IDLE;
      mPos   <= 0;
      mLeft  <= 0;
      mStall <= 0;
      mErr   <= 1'b0;
    end else begin
      case (mPhase)
        P_IDLE: begin
          if (iStart) begin
            mPhase <= P_LOAD;
            mPos   <= 0;
            mStall <= 0;
            mErr   <= 1'b0;
          end
        end
        P_LOAD: begin
          if (iReady) begin
            mStall <= 0;
            if (mPos == N_CH - 1) begin
              mPhase <= P_COMPUTE;
              mLeft  <= COMPUTE_CYCLES;
            end else begin
              mPos <= mPos + 1;
            end
          end else begin
            mStall <= mStall + 1;
`ifdef LOAD_TIMEOUT_EN
            if (mStall + 1 == TIMEOUT_CYCLES) begin
              mPhase <= P_IDLE;
              mErr   <= 1'b1;
            end
`endif
          end
        end
        P_COMPUTE: begin
          mLeft <= mLeft - 1;
          if (mLeft == 1) mPhase <= P_DONE;
        end
        default: begin
          if (iAck) begin
            if (iStart) begin
              mPhase <= P_LOAD;
              mPos   <= 0;
              mStall <= 0;
              mErr   <= 1'b0;
            end else begin
              mPhase <= P_IDLE;
            end
          end
        end
      endcase
    end
  end

  // Expected {loaddata, chan_idx, compute_en, busy, done, err}.
  function automatic logic [9:0] modelExp();
    logic [3:0] ld;
    logic [1:0] ch;
    ld = (mPhase == P_LOAD) ? 4'(1 << mPos) : 4'b0000;
    ch = (mPhase == P_LOAD) ? 2'(mPos) : 2'd0;
    return {ld, ch, mPhase == P_COMPUTE,
            mPhase == P_LOAD || mPhase == P_COMPUTE, mPhase == P_DONE, mErr};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    checkOutput("scoreboard", {22'd0, oLoad, oChan, oComputeEn, oBusy, oDone, oErr},
                {22'd0, modelExp()});
  end

  task automatic applyStimulus(input logic s, input logic r, input logic a);
    iStart = s;
    iReady = r;
    iAck   = a;
    @(posedge clk);
    #1;
  endtask

  // Runs from LOAD channel 0 (start already accepted) through to DONE.
  task automatic runSequence(input bit noise, input int stallChan,
                             output int latency, output int computeLen);
    logic [3:0] want;
    int guard;
    latency = 1;
    for (int ch = 0; ch < N_CH; ch++) begin
      want = 4'(1 << ch);
      checkOutput("load_strobe", {28'd0, oLoad}, {28'd0, want});
      checkOutput("chan_idx", {30'd0, oChan}, ch);
      if (ch == stallChan) begin
        for (int k = 0; k < 3; k++) begin
          applyStimulus(noise, 1'b0, noise);
          latency++;
          checkOutput("stall_hold", {26'd0, oLoad, oChan}, {26'd0, 4'b0100, 2'd2});
        end
      end
      applyStimulus(noise, 1'b1, noise);
      latency++;
    end
    computeLen = 0;
    guard = 0;
    while (oComputeEn && guard < 200) begin
      computeLen++;
      applyStimulus(noise, 1'b0, noise);
      latency++;
      guard++;
    end
    checkOutput("compute_bounded", guard < 200, 1);
    checkOutput("reached_done", {30'd0, oDone, oBusy}, 2'b10);
  endtask

  initial begin
    rstN = 1'b0;
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("reset_outputs", {22'd0, oLoad, oChan, oComputeEn, oBusy, oDone, oErr}, 0);
    rstN = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("idle_ignores_ready_ack", {27'd0, oBusy, oLoad}, 0);

    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("first_strobe", {28'd0, oLoad}, 4'b0001);
    runSequence(1'b0, -1, lat, clen);
    checkOutput("nominal_latency", lat, 21);
    checkOutput("nominal_compute_len", clen, COMPUTE_CYCLES);
    checkOutput("model_pin_done", {22'd0, modelExp()}, 10'b0000_00_0010);

    for (int i = 0; i < 5; i++) begin
      applyStimulus(i == 2, 1'b0, 1'b0);
      checkOutput("done_hold", {27'd0, oDone, oLoad}, 5'b10000);
    end
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("restart_strobe", {27'd0, oDone, oLoad}, 5'b00001);

    runSequence(1'b1, -1, lat, clen);
    checkOutput("noisy_latency", lat, 21);
    checkOutput("noisy_compute_len", clen, COMPUTE_CYCLES);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("ack_to_idle", {30'd0, oDone, oBusy}, 0);

    applyStimulus(1'b1, 1'b0, 1'b0);
    runSequence(1'b0, 2, lat, clen);
    checkOutput("stall_latency", lat, 24);
    applyStimulus(1'b0, 1'b0, 1'b1);

    applyStimulus(1'b1, 1'b0, 1'b0);
    repeat (4) applyStimulus(1'b0, 1'b1, 1'b0);
    repeat (5) applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("mid_compute", {31'd0, oComputeEn}, 1);
    rstN = 1'b0;
    #1;
    checkOutput("async_reset", {22'd0, oLoad, oChan, oComputeEn, oBusy, oDone, oErr}, 0);
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("reset_held", {22'd0, oLoad, oChan, oComputeEn, oBusy, oDone, oErr}, 0);
    rstN = 1'b1;
    repeat (4) applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("idle_after_reset", {22'd0, oLoad, oChan, oComputeEn, oBusy, oDone, oErr}, 0);

    applyStimulus(1'b1, 1'b0, 1'b0);
`ifdef LOAD_TIMEOUT_EN
    repeat (TIMEOUT_CYCLES - 1) applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("before_timeout", {30'd0, oBusy, oErr}, 2'b10);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("timeout_err", {26'd0, oBusy, oErr, oLoad}, 6'b010000);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("err_cleared", {27'd0, oErr, oLoad}, 5'b00001);
`else
    repeat (TIMEOUT_CYCLES + 6) applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("no_timeout", {26'd0, oBusy, oErr, oLoad}, 6'b100001);
`endif
    runSequence(1'b0, -1, lat, clen);
    checkOutput("post_stall_compute_len", clen, COMPUTE_CYCLES);
    applyStimulus(1'b0, 1'b0, 1'b1);

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/load_sequencer.md
Name: load_sequencer

Overview:
Parametrised successor to the single-shot load controller. Sequences a start/load/compute/done cycle across N_CH input channels, one channel at a time.
- Issues a one-hot load strobe per channel and waits on inputdata_ready for each.
- Runs a fixed-length compute phase, then holds done until acknowledged.
- Sits between the input capture registers and the datapath in each lab top level.

Parameters:
N_CH, 4, number of input channels loaded in sequence (>=1)
COMPUTE_CYCLES, 16, length of compute phase in clk cycles (>=1)
CNT_W, 8, compute counter width; must satisfy 2**CNT_W >= COMPUTE_CYCLES
TIMEOUT_CYCLES, 64, LOAD-phase watchdog limit (used only with LOAD_TIMEOUT_EN)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (asserted when 0)
start  input  1  request a new sequence; sampled in IDLE and DONE only
inputdata_ready  input  1  current channel's data is valid; advances the load phase
loaddata  output  N_CH  one-hot load strobe for the active channel; 0 outside LOAD
chan_idx  output  $clog2(N_CH) (min 1)  index of the active channel
compute_en  output  1  high throughout COMPUTE
busy  output  1  high in LOAD and COMPUTE
done  output  1  high in DONE until ack
ack  input  1  consumer acknowledge of done
err  output  1  sticky load-timeout flag; tied 0 when the feature is off

Behaviour:
- Reset (reset=0, async): state=IDLE, chan_idx=0, cnt=0.
  - All outputs 0: loaddata, compute_en, busy, done, err.
- Moore outputs only; every output is a function of the registered state and counters.
- FSM states and transitions:
  - IDLE: start=1 -> LOAD with chan_idx=0. Otherwise stay in IDLE.
  - LOAD: loaddata = 1<<chan_idx; busy=1.
    - inputdata_ready=1 and chan_idx<N_CH-1 -> chan_idx+1, stay in LOAD.
    - inputdata_ready=1 and chan_idx==N_CH-1 -> COMPUTE with cnt=0, chan_idx=0.
    - inputdata_ready=0 -> hold state, index and strobe.
  - COMPUTE: compute_en=1, busy=1, cnt increments every cycle.
    - cnt==COMPUTE_CYCLES-1 -> DONE with cnt=0.
    - COMPUTE lasts exactly COMPUTE_CYCLES cycles.
  - DONE: done=1.
    - ack=1 and start=1 -> LOAD (back-to-back restart, chan_idx=0).
    - ack=1 and start=0 -> IDLE.
    - ack=0 -> hold; start is ignored.
- start is ignored in LOAD and COMPUTE. ack is ignored outside DONE. inputdata_ready is ignored outside LOAD.
- Latency:
  - start high at edge k -> loaddata=0001 from cycle k+1.
  - Minimum sequence, start to done: N_CH + COMPUTE_CYCLES + 1 cycles.
- N_CH=1: a single LOAD beat goes straight to COMPUTE.
- Reset asserted mid-operation: immediate return to the reset state; a partial sequence is abandoned, with no completion or done pulse.
- Counters never wrap in legal operation. Illegal encodings fall through to IDLE.

Optional Feature:
LOAD_TIMEOUT_EN
- Defined:
  - A watchdog counter runs in LOAD and clears on every inputdata_ready.
  - Reaching TIMEOUT_CYCLES consecutive cycles without ready -> set err=1 (sticky) and go to IDLE.
  - err clears only on reset or on the next accepted start.
- Undefined:
  - No watchdog logic is built; err is tied 0.
  - LOAD waits indefinitely.

Decomposition:
- Package controlunit_pkg:
  - State enum {IDLE, LOAD, COMPUTE, DONE} as logic [1:0].
  - Function onehot(idx, n) returning the loaddata vector.
- Sub-module: seq_counter, a parametrised up-counter with clear, enable and terminal-count output.
  - Instantiated for the compute counter.
  - Instantiated again for the watchdog under LOAD_TIMEOUT_EN.
- The FSM stays in load_sequencer.

Test Plan:
- Reset: hold reset=0 for 3 cycles, including mid-COMPUTE -> all outputs 0, state IDLE; release -> nothing happens without start.
- Nominal (N_CH=4, COMPUTE_CYCLES=16):
  - Stimulus: start pulse, then inputdata_ready high continuously.
  - loaddata sequence 0001,0010,0100,1000 on consecutive cycles.
  - compute_en for exactly 16 cycles.
  - done high from cycle 21 after start until ack.
- Stalls: insert 3 idle cycles between ready pulses on channel 2 -> loaddata holds 0100 and chan_idx=2 for those cycles; no channel is skipped.
- Done hold and restart:
  - ack=0 for 5 cycles -> done stays 1; a start pulse during this window is ignored.
  - ack=1 with start=1 -> loaddata=0001 in the next cycle and done=0.
- Ignored inputs: start and ack pulses during LOAD/COMPUTE -> no state change and no extra cycles; inputdata_ready in IDLE -> no effect.
- LOAD_TIMEOUT_EN, TIMEOUT_CYCLES=64:
  - Stall 64 cycles in LOAD -> err=1, state IDLE.
  - Next start -> err=0 and the sequence runs normally.
  - Without the macro, the same stall waits forever with err=0.
